uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, sample helpers.
// Used by uart_rx (and uart_tx).
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned CNT_W                = 16;
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned IDX_W                = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  // 2-of-3 vote used when majority sampling is enabled
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling, one-cycle valid / frame-error pulses.
// Optional macro UART_RX_MAJORITY_EN enables 2-of-3 majority sampling around each sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_busy
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic              rx_s;
  logic              sample_c;
  uart_state_e       state, state_nxt;
  logic [CNT_W-1:0]  clk_cnt, cnt_nxt;
  logic [IDX_W-1:0]  bit_idx, idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt, err_nxt;

  uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Window is the two previous synchronized values plus the current one; decision cycle unchanged
  logic rx_d1, rx_d2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign sample_c = maj3(rx_d2, rx_d1, rx_s);
`else
  assign sample_c = rx_s;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_cnt      <= cnt_nxt;
      bit_idx      <= idx_nxt;
      shift        <= shift_nxt;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= err_nxt;
      rx_busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) state_nxt = START;
      end

      START: begin
        if (clk_cnt == HALF_CNT) begin
          cnt_nxt   = '0;
          state_nxt = sample_c ? IDLE : DATA;
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = sample_c;
          if (bit_idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (sample_c) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      // A held-low line reports one error, then waits for idle before rearming
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
